// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: NUM_CH outputs share one period counter.
// Latency: one clock from counter value to output pin; period_end is registered.
// Backpressure: none. Period/duty/mode are shadowed and only reload at a period boundary.
//
// Ports:
//   clk, reset_n        - rising-edge clock, asynchronous active-low reset
//   en                  - run enable; 0 stops the counter and idles the outputs
//   mode                - 0 edge-aligned, 1 center-aligned (shadowed)
//   period              - period value P (shadowed)
//   duty                - per-channel duty, channel i at [i*W +: W] (shadowed)
//   polarity            - per-channel active level, 1 = active-high (live)
//   load                - strobe requesting a shadow reload at the next boundary
//   out                 - registered PWM outputs
//   period_end          - registered one-cycle pulse per completed period
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                mode,
  input  logic [W-1:0]        period,
  input  logic [NUM_CH*W-1:0] duty,
  input  logic [NUM_CH-1:0]   polarity,
  input  logic                load,
  output logic [NUM_CH-1:0]   out,
  output logic                period_end
);

  logic [W-1:0]        count_q, count_d;
  logic                dir_q, dir_d;        // 0 = up, 1 = down
  logic                running_q, running_d;
  logic                pending_q, pending_d;
  logic [W-1:0]        per_a_q, per_a_d;
  logic [NUM_CH*W-1:0] duty_a_q, duty_a_d;
  logic                mode_a_q, mode_a_d;
  logic [NUM_CH-1:0]   out_q, out_d;
  logic                pe_q, pe_d;

  logic                boundary;
  logic [W-1:0]        count_nxt;
  logic                dir_nxt;
  logic [NUM_CH-1:0]   raw;

  // Boundary is the last count of the current period, i.e. the next count is 0.
  // P==1 in center mode never sees dir==down at count 1 on the first pass, hence
  // the extra term.
  always_comb begin
    boundary = 1'b0;
    if (per_a_q == '0) begin
      boundary = 1'b1;
    end else if (mode_a_q) begin
      boundary = (count_q == W'(1)) && (dir_q || (per_a_q == W'(1)));
    end else begin
      boundary = (count_q == per_a_q);
    end
  end

  // Free-running counter sequence when no shadow reload happens.
  always_comb begin
    count_nxt = count_q;
    dir_nxt   = dir_q;
    if (per_a_q == '0) begin
      count_nxt = '0;
      dir_nxt   = 1'b0;
    end else if (!mode_a_q) begin
      count_nxt = (count_q == per_a_q) ? '0 : count_q + W'(1);
      dir_nxt   = 1'b0;
    end else if (count_q == per_a_q) begin
      count_nxt = count_q - W'(1);
      dir_nxt   = 1'b1;
    end else if (count_q == '0) begin
      count_nxt = W'(1);
      dir_nxt   = 1'b0;
    end else if (dir_q) begin
      count_nxt = count_q - W'(1);
    end else begin
      count_nxt = count_q + W'(1);
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = (count_q < duty_a_q[i*W +: W]);
    end
  end

  always_comb begin
    count_d   = count_q;
    dir_d     = dir_q;
    running_d = running_q;
    pending_d = pending_q;
    per_a_d   = per_a_q;
    duty_a_d  = duty_a_q;
    mode_a_d  = mode_a_q;
    out_d     = out_q;
    pe_d      = pe_q;

    if (!en) begin
      // Idle: outputs sit at the inactive level; a pending load survives.
      count_d   = '0;
      dir_d     = 1'b0;
      running_d = 1'b0;
      pe_d      = 1'b0;
      out_d     = ~polarity;
    end else if (!running_q) begin
      // Start: fresh shadow values, any earlier request is superseded.
      per_a_d   = period;
      duty_a_d  = duty;
      mode_a_d  = mode;
      count_d   = '0;
      dir_d     = 1'b0;
      running_d = 1'b1;
      pending_d = 1'b0;
      pe_d      = 1'b0;
      out_d     = ~polarity;
    end else begin
      out_d     = ~(raw ^ polarity);
      pe_d      = boundary;
      pending_d = (pending_q | load) & ~boundary;
      if (boundary && (pending_q || load)) begin
        per_a_d  = period;
        duty_a_d = duty;
        mode_a_d = mode;
        count_d  = '0;
        dir_d    = 1'b0;
      end else begin
        count_d  = count_nxt;
        dir_d    = dir_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      pending_q <= 1'b0;
      per_a_q   <= '0;
      duty_a_q  <= '0;
      mode_a_q  <= 1'b0;
      out_q     <= '0;
      pe_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      pending_q <= pending_d;
      per_a_q   <= per_a_d;
      duty_a_q  <= duty_a_d;
      mode_a_q  <= mode_a_d;
      out_q     <= out_d;
      pe_q      <= pe_d;
    end
  end

  assign out        = out_q;
  assign period_end = pe_q;

endmodule
